// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slots of {valid, ctrl, data}
// with hold (stall), bubble (flush) and saturating stall/flush event counters.

module pipe_stage_slot #(
  parameter int CTRL_W   = 7,
  parameter int DATA_W   = 121,
  parameter int CLR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid_nxt,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);
  logic [CTRL_W-1:0] ctrl_nxt;
  logic [DATA_W-1:0] data_nxt;

  // ctrl is zero whenever the slot is empty, so ctrl_o needs no output gating.
  always_comb begin
    valid_nxt = valid;
    ctrl_nxt  = ctrl;
    data_nxt  = data;
    if (flush) begin
      valid_nxt = 1'b0;
      ctrl_nxt  = '0;
      if (CLR_DATA != 0) data_nxt = '0;
    end else if (!stall) begin
      valid_nxt = in_valid;
      ctrl_nxt  = in_valid ? in_ctrl : '0;
      if (in_valid)           data_nxt = in_data;
      else if (CLR_DATA != 0) data_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else begin
      valid <= valid_nxt;
      ctrl  <= ctrl_nxt;
      data  <= data_nxt;
    end
  end
endmodule

module pipe_stage_reg #(
  parameter int CTRL_W   = 7,
  parameter int DATA_W   = 121,
  parameter int DEPTH    = 1,
  parameter int CLR_DATA = 0,
  parameter int CNT_W    = 16,
  localparam int OCC_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              cnt_clr_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [OCC_W-1:0]  occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);
  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("pipe_stage_reg: DEPTH must be within 1..4");
    end
  endgenerate

  // Index 0 of each chain is the upstream input; index k+1 is slot k.
  logic [DEPTH:0]             chain_valid;
  logic [DEPTH:0][CTRL_W-1:0] chain_ctrl;
  logic [DEPTH:0][DATA_W-1:0] chain_data;
  logic [DEPTH-1:0]           valid_nxt;
  logic [OCC_W-1:0]           occ_nxt;

  assign chain_valid[0] = valid_i;
  assign chain_ctrl[0]  = ctrl_i;
  assign chain_data[0]  = data_i;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_slot
      pipe_stage_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) u_slot (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (flush_i),
        .stall    (stall_i),
        .in_valid (chain_valid[k]),
        .in_ctrl  (chain_ctrl[k]),
        .in_data  (chain_data[k]),
        .valid_nxt(valid_nxt[k]),
        .valid    (chain_valid[k+1]),
        .ctrl     (chain_ctrl[k+1]),
        .data     (chain_data[k+1])
      );
    end
  endgenerate

  assign valid_o = chain_valid[DEPTH];
  assign ctrl_o  = chain_ctrl[DEPTH];
  assign data_o  = chain_data[DEPTH];

  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) occ_nxt = occ_nxt + OCC_W'(valid_nxt[i]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) occ_o <= '0;
    else       occ_o <= occ_nxt;
  end

  // A flush only counts when it actually killed something.
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_i && !flush_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush_i && |chain_valid[DEPTH:1] && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a vector table drives a DEPTH=3/CLR_DATA=0 instance, and
// hand sequences cover a DEPTH=2/CLR_DATA=1/CNT_W=4 instance.

module tb_pipe_stage_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // ---------------- instance A: DEPTH=3, CLR_DATA=0 ----------------
  logic         a_rst, a_stall, a_flush, a_valid, a_clr;
  logic [6:0]   a_ctrl;
  logic [120:0] a_data;
  logic         a_valid_o;
  logic [6:0]   a_ctrl_o;
  logic [120:0] a_data_o;
  logic [1:0]   a_occ;
  logic [15:0]  a_scnt, a_fcnt;

  pipe_stage_reg #(.CTRL_W(7), .DATA_W(121), .DEPTH(3), .CLR_DATA(0), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_i(a_rst), .stall_i(a_stall), .flush_i(a_flush), .valid_i(a_valid),
    .ctrl_i(a_ctrl), .data_i(a_data), .cnt_clr_i(a_clr), .valid_o(a_valid_o),
    .ctrl_o(a_ctrl_o), .data_o(a_data_o), .occ_o(a_occ), .stall_cnt_o(a_scnt),
    .flush_cnt_o(a_fcnt)
  );

  // ---------------- instance B: DEPTH=2, CLR_DATA=1, CNT_W=4 ----------------
  logic        b_rst, b_stall, b_flush, b_valid, b_clr;
  logic [6:0]  b_ctrl;
  logic [15:0] b_data;
  logic        b_valid_o;
  logic [6:0]  b_ctrl_o;
  logic [15:0] b_data_o;
  logic [1:0]  b_occ;
  logic [3:0]  b_scnt, b_fcnt;

  pipe_stage_reg #(.CTRL_W(7), .DATA_W(16), .DEPTH(2), .CLR_DATA(1), .CNT_W(4)) u_b (
    .clk_i(clk), .rst_i(b_rst), .stall_i(b_stall), .flush_i(b_flush), .valid_i(b_valid),
    .ctrl_i(b_ctrl), .data_i(b_data), .cnt_clr_i(b_clr), .valid_o(b_valid_o),
    .ctrl_o(b_ctrl_o), .data_o(b_data_o), .occ_o(b_occ), .stall_cnt_o(b_scnt),
    .flush_cnt_o(b_fcnt)
  );

  typedef struct {
    logic         rst, stall, flush, valid, clr;
    logic [6:0]   ctrl;
    logic [120:0] data;
    logic         e_valid;
    logic [6:0]   e_ctrl;
    logic [120:0] e_data;
    logic [1:0]   e_occ;
    logic [15:0]  e_scnt, e_fcnt;
  } vec_t;

  vec_t vt[24];

  function automatic vec_t mk(logic rst, logic stall, logic flush, logic valid, logic clr,
                              logic [6:0] ctrl, logic [120:0] data, logic ev, logic [6:0] ec,
                              logic [120:0] ed, logic [1:0] eo, logic [15:0] es, logic [15:0] ef);
    vec_t v;
    v.rst = rst; v.stall = stall; v.flush = flush; v.valid = valid; v.clr = clr;
    v.ctrl = ctrl; v.data = data; v.e_valid = ev; v.e_ctrl = ec; v.e_data = ed;
    v.e_occ = eo; v.e_scnt = es; v.e_fcnt = ef;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(logic rst, logic stall, logic flush, logic valid, logic clr,
                         logic [6:0] ctrl, logic [15:0] data);
    b_rst = rst; b_stall = stall; b_flush = flush; b_valid = valid; b_clr = clr;
    b_ctrl = ctrl; b_data = data;
  endtask

  task automatic chk_b(string name, logic ev, logic [6:0] ec, logic [15:0] ed,
                       logic [1:0] eo, logic [3:0] es, logic [3:0] ef);
    checks++;
    if (b_valid_o === ev && b_ctrl_o === ec && b_data_o === ed && b_occ === eo &&
        b_scnt === es && b_fcnt === ef)
      passed++;
    else
      $display("FAIL %s: got v=%0b c=%h d=%h occ=%0d sc=%0d fc=%0d, want v=%0b c=%h d=%h occ=%0d sc=%0d fc=%0d",
               name, b_valid_o, b_ctrl_o, b_data_o, b_occ, b_scnt, b_fcnt, ev, ec, ed, eo, es, ef);
  endtask

  initial begin
    // rst stall flush valid clr ctrl data | valid ctrl data occ stall_cnt flush_cnt
    vt[0]  = mk(1,0,0,1,0,7'h7F,121'hFF, 0,7'h00,121'h00,0,0,0);
    vt[1]  = mk(1,0,0,1,0,7'h7F,121'hFF, 0,7'h00,121'h00,0,0,0);
    vt[2]  = mk(0,0,0,1,0,7'h55,121'hA1, 0,7'h00,121'h00,1,0,0);
    vt[3]  = mk(0,0,0,1,0,7'h11,121'hB2, 0,7'h00,121'h00,2,0,0);
    vt[4]  = mk(0,0,0,1,0,7'h22,121'hC3, 1,7'h55,121'hA1,3,0,0);
    vt[5]  = mk(0,1,0,1,0,7'h33,121'hD4, 1,7'h55,121'hA1,3,1,0);
    vt[6]  = mk(0,1,0,1,0,7'h33,121'hD4, 1,7'h55,121'hA1,3,2,0);
    vt[7]  = mk(0,0,0,0,0,7'h7F,121'hEE, 1,7'h11,121'hB2,2,2,0);
    vt[8]  = mk(0,0,0,0,0,7'h7F,121'hEE, 1,7'h22,121'hC3,1,2,0);
    vt[9]  = mk(0,0,0,0,0,7'h7F,121'hEE, 0,7'h00,121'hC3,0,2,0);
    vt[10] = mk(0,0,1,0,0,7'h7F,121'hEE, 0,7'h00,121'hC3,0,2,0);
    vt[11] = mk(0,0,0,1,0,7'h55,121'h11, 0,7'h00,121'hC3,1,2,0);
    vt[12] = mk(0,0,0,1,0,7'h66,121'h22, 0,7'h00,121'hC3,2,2,0);
    vt[13] = mk(0,0,0,1,0,7'h77,121'h33, 1,7'h55,121'h11,3,2,0);
    vt[14] = mk(0,1,1,1,0,7'h7F,121'h99, 0,7'h00,121'h11,0,2,1);
    vt[15] = mk(0,0,0,1,0,7'h0A,121'h44, 0,7'h00,121'h11,1,2,1);
    vt[16] = mk(0,0,0,1,0,7'h0B,121'h55, 0,7'h00,121'h11,2,2,1);
    vt[17] = mk(0,0,0,1,0,7'h0C,121'h66, 1,7'h0A,121'h44,3,2,1);
    vt[18] = mk(0,1,0,1,0,7'h0D,121'h77, 1,7'h0A,121'h44,3,3,1);
    vt[19] = mk(1,1,0,1,0,7'h0D,121'h77, 0,7'h00,121'h00,0,0,0);
    vt[20] = mk(0,0,0,1,0,7'h0D,121'h77, 0,7'h00,121'h00,1,0,0);
    vt[21] = mk(0,0,0,0,0,7'h7F,121'hEE, 0,7'h00,121'h00,1,0,0);
    vt[22] = mk(0,0,0,0,0,7'h7F,121'hEE, 1,7'h0D,121'h77,1,0,0);
    vt[23] = mk(0,1,0,0,1,7'h7F,121'hEE, 1,7'h0D,121'h77,1,0,0);

    a_rst = 1; a_stall = 0; a_flush = 0; a_valid = 0; a_clr = 0; a_ctrl = '0; a_data = '0;
    drive_b(1, 0, 0, 0, 0, 7'h00, 16'h0000);
    #2;

    foreach (vt[i]) begin
      a_rst = vt[i].rst; a_stall = vt[i].stall; a_flush = vt[i].flush;
      a_valid = vt[i].valid; a_clr = vt[i].clr; a_ctrl = vt[i].ctrl; a_data = vt[i].data;
      tick();
      checks++;
      if (a_valid_o === vt[i].e_valid && a_ctrl_o === vt[i].e_ctrl && a_data_o === vt[i].e_data &&
          a_occ === vt[i].e_occ && a_scnt === vt[i].e_scnt && a_fcnt === vt[i].e_fcnt)
        passed++;
      else
        $display("FAIL vec%0d: got v=%0b c=%h d=%h occ=%0d sc=%0d fc=%0d, want v=%0b c=%h d=%h occ=%0d sc=%0d fc=%0d",
                 i, a_valid_o, a_ctrl_o, a_data_o, a_occ, a_scnt, a_fcnt, vt[i].e_valid,
                 vt[i].e_ctrl, vt[i].e_data, vt[i].e_occ, vt[i].e_scnt, vt[i].e_fcnt);
    end
    a_rst = 0; a_stall = 0; a_flush = 0; a_valid = 0; a_clr = 0;

    // Instance B: reset with live inputs, then stall hold on {2,1}.
    drive_b(1, 1, 0, 1, 0, 7'h7F, 16'hFFFF);
    tick(); chk_b("b_rst0", 0, 7'h00, 16'h0000, 0, 0, 0);
    tick(); chk_b("b_rst1", 0, 7'h00, 16'h0000, 0, 0, 0);
    drive_b(0, 0, 0, 1, 0, 7'h01, 16'h0001); tick();
    chk_b("b_in1", 0, 7'h00, 16'h0000, 1, 0, 0);
    drive_b(0, 0, 0, 1, 0, 7'h02, 16'h0002); tick();
    chk_b("b_in2", 1, 7'h01, 16'h0001, 2, 0, 0);
    drive_b(0, 1, 0, 1, 0, 7'h03, 16'h0003);
    repeat (4) tick();
    chk_b("b_stall4", 1, 7'h01, 16'h0001, 2, 4, 0);
    drive_b(0, 0, 0, 1, 0, 7'h03, 16'h0003); tick();
    chk_b("b_rel2", 1, 7'h02, 16'h0002, 2, 4, 0);
    drive_b(0, 0, 0, 0, 0, 7'h7F, 16'hBEEF); tick();
    chk_b("b_rel3", 1, 7'h03, 16'h0003, 1, 4, 0);
    drive_b(0, 0, 0, 1, 0, 7'h04, 16'h0004); tick();
    chk_b("b_bubble_clr", 0, 7'h00, 16'h0000, 1, 4, 0);
    drive_b(0, 0, 0, 1, 0, 7'h05, 16'h0005); tick();
    chk_b("b_in4", 1, 7'h04, 16'h0004, 2, 4, 0);

    // Flush together with stall on a full pipe: flush wins, data cleared.
    drive_b(0, 1, 1, 1, 0, 7'h06, 16'h0006); tick();
    chk_b("b_flush_stall", 0, 7'h00, 16'h0000, 0, 4, 1);
    drive_b(0, 0, 1, 1, 0, 7'h06, 16'h0006); tick();
    chk_b("b_flush_empty", 0, 7'h00, 16'h0000, 0, 4, 1);
    drive_b(0, 0, 0, 0, 0, 7'h7F, 16'hFFFF);
    repeat (2) tick();
    chk_b("b_bubble_ctrl", 0, 7'h00, 16'h0000, 0, 4, 1);

    // Saturation at 15, then clear beats a same-cycle increment.
    drive_b(0, 1, 0, 0, 0, 7'h00, 16'h0000);
    repeat (20) tick();
    chk_b("b_sat", 0, 7'h00, 16'h0000, 0, 15, 1);
    drive_b(0, 1, 0, 0, 1, 7'h00, 16'h0000); tick();
    chk_b("b_clr", 0, 7'h00, 16'h0000, 0, 0, 0);
    drive_b(0, 1, 0, 0, 0, 7'h00, 16'h0000); tick();
    chk_b("b_after_clr", 0, 7'h00, 16'h0000, 0, 1, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
